// File: rtl/mips_isa_pkg.sv
// Shared encodings for the 10-instruction MIPS subset: opcodes, functs,
// flag bit positions and the hazard Tnew value used by the stage controllers.
package mips_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam int NUM_FLAGS = 10;

   // Bit positions inside the packed flag vector {jr,jal,j,beq,sw,lw,lui,ori,subu,addu}
   localparam int FLAG_ADDU = 0;
   localparam int FLAG_SUBU = 1;
   localparam int FLAG_ORI  = 2;
   localparam int FLAG_LUI  = 3;
   localparam int FLAG_LW   = 4;
   localparam int FLAG_SW   = 5;
   localparam int FLAG_BEQ  = 6;
   localparam int FLAG_J    = 7;
   localparam int FLAG_JAL  = 8;
   localparam int FLAG_JR   = 9;

   localparam logic [1:0] TNEW_LW   = 2'b01;
   localparam logic [1:0] TNEW_NONE = 2'b00;

   typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/mips_instr_decoder.sv
// One-hot decoder for the MIPS subset, plus a single registered copy of the
// flags (with reg_write and Tnew) that feeds the next pipeline stage.
module mips_instr_decoder
   import mips_isa_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic       addu,
   output logic       subu,
   output logic       ori,
   output logic       lui,
   output logic       lw,
   output logic       sw,
   output logic       beq,
   output logic       j,
   output logic       jal,
   output logic       jr,
   output logic       invalid,
   output logic       reg_write,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic [9:0] flags_q,
   output logic       reg_write_q,
   output logic [1:0] tnew_q
);

   flags_t flags;

   // func only matters for R-type; unknown encodings leave every flag clear
   always_comb begin
      flags = '0;
      case (op)
         OP_RTYPE: begin
            case (func)
               FN_ADDU: flags[FLAG_ADDU] = 1'b1;
               FN_SUBU: flags[FLAG_SUBU] = 1'b1;
               FN_JR:   flags[FLAG_JR]   = 1'b1;
               default: flags = '0;
            endcase
         end
         OP_ORI:  flags[FLAG_ORI] = 1'b1;
         OP_LUI:  flags[FLAG_LUI] = 1'b1;
         OP_LW:   flags[FLAG_LW]  = 1'b1;
         OP_SW:   flags[FLAG_SW]  = 1'b1;
         OP_BEQ:  flags[FLAG_BEQ] = 1'b1;
         OP_J:    flags[FLAG_J]   = 1'b1;
         OP_JAL:  flags[FLAG_JAL] = 1'b1;
         default: flags = '0;
      endcase
   end

   assign addu = flags[FLAG_ADDU];
   assign subu = flags[FLAG_SUBU];
   assign ori  = flags[FLAG_ORI];
   assign lui  = flags[FLAG_LUI];
   assign lw   = flags[FLAG_LW];
   assign sw   = flags[FLAG_SW];
   assign beq  = flags[FLAG_BEQ];
   assign j    = flags[FLAG_J];
   assign jal  = flags[FLAG_JAL];
   assign jr   = flags[FLAG_JR];

   assign invalid    = ~|flags;
   assign reg_write  = flags[FLAG_ADDU] | flags[FLAG_SUBU] | flags[FLAG_ORI] |
                       flags[FLAG_LUI]  | flags[FLAG_LW]   | flags[FLAG_JAL];
   assign mem_write  = flags[FLAG_SW];
   assign mem_to_reg = flags[FLAG_LW];

   // An invalid instruction captures as all-zero flags, i.e. a bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q     <= '0;
         reg_write_q <= 1'b0;
      end else if (en) begin
         flags_q     <= flags;
         reg_write_q <= reg_write;
      end
   end

   assign tnew_q = flags_q[FLAG_LW] ? TNEW_LW : TNEW_NONE;

endmodule

// File: tb/tb_mips_instr_decoder.sv
// Bench for mips_instr_decoder: full op/func sweep, directed pipeline-register
// scenarios and a randomized stream checked against a table-driven model.
module tb_mips_instr_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [5:0] op = 6'h00;
   logic [5:0] func = 6'h00;
   logic       addu, subu, ori, lui, lw, sw, beq, j, jal, jr;
   logic       invalid, reg_write, mem_write, mem_to_reg;
   logic [9:0] flags_q;
   logic       reg_write_q;
   logic [1:0] tnew_q;

   int total = 0;
   int bad   = 0;

   // Instruction table, listed in flag-bit order; -1 func means "any"
   int enc_op   [10] = '{'h00, 'h00, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h02, 'h03, 'h00};
   int enc_func [10] = '{'h21, 'h23,   -1,   -1,   -1,   -1,   -1,   -1,   -1, 'h08};
   bit writes   [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 0};

   logic [9:0] model_q  = '0;
   logic       model_rw = 1'b0;

   mips_instr_decoder dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .func(func),
      .addu(addu), .subu(subu), .ori(ori), .lui(lui), .lw(lw), .sw(sw),
      .beq(beq), .j(j), .jal(jal), .jr(jr), .invalid(invalid),
      .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .flags_q(flags_q), .reg_write_q(reg_write_q), .tnew_q(tnew_q)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] ref_flags(input logic [5:0] o, input logic [5:0] f);
      logic [9:0] r = '0;
      for (int k = 0; k < 10; k++)
         if (int'(o) == enc_op[k] && (enc_func[k] < 0 || int'(f) == enc_func[k]))
            r[k] = 1'b1;
      return r;
   endfunction

   function automatic logic ref_rw(input logic [9:0] fl);
      logic r = 1'b0;
      for (int k = 0; k < 10; k++)
         if (fl[k] && writes[k]) r = 1'b1;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%h want=%h (op=%h func=%h)", tag, got, want, op, func);
      end
   endtask

   task automatic checkComb(input string tag);
      logic [9:0] e;
      e = ref_flags(op, func);
      checkOutput({tag, ".flags"}, 32'({jr, jal, j, beq, sw, lw, lui, ori, subu, addu}), 32'(e));
      checkOutput({tag, ".ctl"}, 32'({invalid, reg_write, mem_write, mem_to_reg}),
                  32'({e == 10'd0, ref_rw(e), e[5], e[4]}));
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, ".flags_q"}, 32'(flags_q), 32'(model_q));
      checkOutput({tag, ".rw_q"}, 32'(reg_write_q), 32'(model_rw));
      checkOutput({tag, ".tnew_q"}, 32'(tnew_q), model_q[4] ? 32'd1 : 32'd0);
   endtask

   // Drive inputs, advance one edge while updating the model, settle after the edge
   task automatic applyStimulus(input logic r, input logic e, input logic [5:0] o, input logic [5:0] f);
      reset = r; en = e; op = o; func = f;
      @(posedge clk);
      if (r) begin
         model_q = '0; model_rw = 1'b0;
      end else if (e) begin
         model_q = ref_flags(o, f); model_rw = ref_rw(model_q);
      end
      #1;
   endtask

   initial begin
      logic [5:0] s_op [7] = '{6'h23, 6'h00, 6'h2B, 6'h04, 6'h02, 6'h00, 6'h0F};
      logic [5:0] s_fn [7] = '{6'h00, 6'h21, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
      logic [5:0] ro, rf;
      int pick;

      // Combinational sweep of every op/func pair
      for (int o = 0; o < 64; o++)
         for (int f = 0; f < 64; f++) begin
            op = 6'(o); func = 6'(f); #1;
            checkComb("sweep");
         end

      op = 6'h00; func = 6'h21; #1;
      checkOutput("addu_dir", 32'({addu, reg_write}), 32'b11);
      op = 6'h00; func = 6'h00; #1;
      checkOutput("nop_invalid", 32'(invalid), 32'd1);
      op = 6'h0D; func = 6'h21; #1;
      checkOutput("ori_ignore_func", 32'({ori, addu}), 32'b10);
      op = 6'h2B; #1;
      checkOutput("sw_ctl", 32'({mem_write, reg_write}), 32'b10);

      // Reset held with lw applied
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 1'b1, 6'h23, 6'h00);
         checkOutput("rst.flags_q", 32'(flags_q), 32'h0);
         checkOutput("rst.tnew_q", 32'(tnew_q), 32'h0);
      end
      applyStimulus(1'b0, 1'b1, 6'h23, 6'h00);
      checkOutput("lw.flags_q", 32'(flags_q), 32'h010);
      checkOutput("lw.tnew_q", 32'(tnew_q), 32'h1);
      checkOutput("lw.rw_q", 32'(reg_write_q), 32'h1);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 6'h2B, 6'h00);
         checkOutput("hold.flags_q", 32'(flags_q), 32'h010);
      end
      applyStimulus(1'b0, 1'b1, 6'h2B, 6'h00);
      checkOutput("sw.flags_q", 32'(flags_q), 32'h020);
      checkOutput("sw.tnew_q", 32'(tnew_q), 32'h0);
      checkOutput("sw.rw_q", 32'(reg_write_q), 32'h0);

      applyStimulus(1'b0, 1'b1, 6'h03, 6'h00);
      checkOutput("jal.flags_q", 32'(flags_q), 32'h100);
      checkOutput("jal.rw_q", 32'(reg_write_q), 32'h1);
      applyStimulus(1'b1, 1'b1, 6'h23, 6'h00);
      checkOutput("rst_over_en", 32'(flags_q), 32'h0);

      // Back-to-back stream
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, 1'b1, s_op[k], s_fn[k]);
         checkRegs("stream");
         checkOutput("stream.tnew", 32'(tnew_q), (k == 0) ? 32'd1 : 32'd0);
      end

      // Randomized stream biased toward legal encodings
      for (int k = 0; k < 400; k++) begin
         ro = 6'($urandom_range(0, 63));
         rf = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) begin
            pick = $urandom_range(0, 9);
            ro = 6'(enc_op[pick]);
            if (enc_func[pick] >= 0) rf = 6'(enc_func[pick]);
         end
         applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, ro, rf);
         checkComb("rand");
         checkRegs("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
